// File: rtl/mdu_div_pkg.sv
// Shared constants, FSM encoding and helpers for the mdu_div radix-2 restoring divider.
// Build option: define DIV_SPECIAL_BYPASS_EN to let divide-by-zero/overflow skip CALC.
package mdu_div_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    return {{(XLEN - 32){x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract divisor, set quotient bit.
module mdu_div_step
  import mdu_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          qbit;

  // Partial remainder is always below the divisor, so XLEN+1 bits hold the shifted value.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign qbit    = ~diff[XLEN];
  assign rem_o   = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], qbit};

endmodule

// File: rtl/mdu_div.sv
// Multi-cycle radix-2 restoring divider for div/divu/rem/remu and their W variants.
// Build option: DIV_SPECIAL_BYPASS_EN sends divide-by-zero/overflow straight to DONE.
module mdu_div
  import mdu_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  div_q, div_d;
  logic [XLEN-1:0]  spec_res_q, spec_res_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             is_rem_q, is_rem_d;
  logic             is_word_q, is_word_d;
  logic             special_q, special_d;

  logic [XLEN-1:0] eff_a, eff_b, mag_a, mag_b, min_neg;
  logic [XLEN-1:0] spec_sel, spec_res;
  logic [XLEN-1:0] step_rem, step_quo, quo_fin, rem_fin, fin_sel, fin_res;
  logic            sa, sb, div_zero, overflow, special, accept;

  // Operand preparation at acceptance.
  always_comb begin
    if (is_word) begin
      eff_a = is_signed ? sext_word(in_a) : {32'b0, in_a[31:0]};
      eff_b = is_signed ? sext_word(in_b) : {32'b0, in_b[31:0]};
    end else begin
      eff_a = in_a;
      eff_b = in_b;
    end
    sa       = is_signed & eff_a[XLEN-1];
    sb       = is_signed & eff_b[XLEN-1];
    mag_a    = sa ? -eff_a : eff_a;
    mag_b    = sb ? -eff_b : eff_b;
    min_neg  = is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = (eff_b == '0);
    overflow = is_signed & (eff_a == min_neg) & (eff_b == '1);
    special  = div_zero | overflow;
    if (div_zero) begin
      spec_sel = is_rem ? eff_a : '1;
    end else begin
      spec_sel = is_rem ? '0 : eff_a;
    end
    spec_res = is_word ? sext_word(spec_sel) : spec_sel;
  end

  mdu_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Final sign correction on the last step's output, registered on entry to DONE.
  always_comb begin
    quo_fin = neg_q_q ? -step_quo : step_quo;
    rem_fin = neg_r_q ? -step_rem : step_rem;
    fin_sel = is_rem_q ? rem_fin : quo_fin;
    fin_res = is_word_q ? sext_word(fin_sel) : fin_sel;
  end

  assign accept = in_valid & (state_q == StIdle) & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    is_rem_d   = is_rem_q;
    is_word_d  = is_word_q;
    special_d  = special_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StCalc;
          cnt_d      = is_word ? CNT_W'(31) : CNT_W'(63);
          rem_d      = '0;
          // Word dividends sit in the top half so 32 steps consume exactly their bits.
          quo_d      = is_word ? {mag_a[31:0], 32'b0} : mag_a;
          div_d      = mag_b;
          spec_res_d = spec_res;
          neg_q_d    = sa ^ sb;
          neg_r_d    = sa;
          is_rem_d   = is_rem;
          is_word_d  = is_word;
          special_d  = special;
`ifdef DIV_SPECIAL_BYPASS_EN
          if (special) begin
            state_d  = StDone;
            result_d = spec_res;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = StDone;
          result_d = special_q ? spec_res_q : fin_res;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      is_word_q  <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      is_rem_q   <= is_rem_d;
      is_word_q  <= is_word_d;
      special_q  <= special_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StCalc) | (state_q == StDone);
  assign out_result = result_q;

endmodule

// File: tb/tb_mdu_div.sv
// Directed self-checking bench for mdu_div: results, latency, stall, flush and async reset.
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        is_signed;
  logic        is_rem;
  logic        is_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam int LatD = 65;
  localparam int LatW = 33;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SpLatD = 1;
  localparam int SpLatW = 1;
`else
  localparam int SpLatD = 65;
  localparam int SpLatW = 33;
`endif

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        r;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  mdu_div dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .is_signed  (is_signed),
    .is_rem     (is_rem),
    .is_word    (is_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issue one request; lat counts clock edges from the accepting edge (1) to first out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic r, input logic w, output logic [63:0] res,
                        output int lat);
    @(negedge clk);
    in_a = a; in_b = b; is_signed = s; is_rem = r; is_word = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_table(input vec_t v[]);
    logic [63:0] res;
    int          lat;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, v[i].r, v[i].w, res, lat);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].exp);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL reset: got rdy/vld/busy=%b res=%h expected 100 res=0",
               {in_ready, out_valid, busy}, out_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v[];
    v = new[5];
    v[0] = '{"divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, LatD};
    v[1] = '{"remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, LatD};
    v[2] = '{"divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0, 1'b0,
             64'h0FFF_FFFF_FFFF_FFFF, LatD};
    v[3] = '{"divuw_sext", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, LatW};
    v[4] = '{"remuw_trunc", 64'h5_0000_0011, 64'h7_0000_0005, 1'b0, 1'b1, 1'b1,
             64'd2, LatW};
    run_table(v);
  endtask

  task automatic test_signed();
    vec_t v[];
    v = new[6];
    v[0] = '{"div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LatD};
    v[1] = '{"rem_m7_2", -64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, LatD};
    v[2] = '{"div_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LatD};
    v[3] = '{"rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 64'd1, LatD};
    v[4] = '{"divw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, LatW};
    v[5] = '{"remw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, LatW};
    run_table(v);
  endtask

  task automatic test_special();
    vec_t v[];
    v = new[7];
    v[0] = '{"divu_by0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, SpLatD};
    v[1] = '{"remu_by0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 64'd5, SpLatD};
    v[2] = '{"divuw_by0", 64'h1_0000_0005, 64'h1_0000_0000, 1'b0, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, SpLatW};
    v[3] = '{"remuw_by0", 64'h0000_0000_8000_0003, 64'h2_0000_0000, 1'b0, 1'b1, 1'b1,
             64'hFFFF_FFFF_8000_0003, SpLatW};
    v[4] = '{"div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, SpLatD};
    v[5] = '{"rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
             64'd0, SpLatD};
    v[6] = '{"divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
             64'hFFFF_FFFF_8000_0000, SpLatW};
    run_table(v);
  endtask

  task automatic test_stall();
    logic [63:0] res;
    int          lat;
    out_ready = 1'b0;
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 64'd14 || lat !== LatD) begin
      errors++;
      $display("FAIL stall_first: got %h lat %0d expected %h lat %0d", res, lat, 64'd14, LatD);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || out_result !== 64'd14) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got vld/rdy/busy=%b res=%h expected 101 res=%h",
                 i, {out_valid, in_ready, busy}, out_result, 64'd14);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release: got vld/rdy/busy=%b expected 010",
               {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int          lat;
    logic        seen;
    // Flush on the same edge as a request: nothing is accepted.
    @(negedge clk);
    in_a = 64'd9; in_b = 64'd3; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL flush_accept: got rdy/busy=%b expected 10", {in_ready, busy});
    end
    // Flush in the CALC cycle whose counter reads 20 (44th cycle after acceptance).
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (43) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL flush_calc: got rdy/vld/busy=%b expected 100",
               {in_ready, out_valid, busy});
    end
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: got out_valid seen=%b expected 0", seen);
    end
    run_op(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 64'd100 || lat !== LatD) begin
      errors++;
      $display("FAIL flush_after: got %h lat %0d expected %h lat %0d", res, lat, 64'd100, LatD);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    in_a = 64'd77; in_b = 64'd5; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: got rdy/vld/busy=%b res=%h expected 100 res=0",
               {in_ready, out_valid, busy}, out_result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd77, 64'd5, 1'b0, 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== 64'd2 || lat !== LatD) begin
      errors++;
      $display("FAIL after_reset: got %h lat %0d expected %h lat %0d", res, lat, 64'd2, LatD);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
